mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares the single data-memory port (MEMU) between the instruction-fetch
//   master (IFU) and the load/store master (EXU/LSU path) of the npc core.
//   Accepts one request at a time, issues it to memory, and routes the
//   response back to the owning master.
//   Exactly one transaction is in flight at any time. Sits between
//   IFU/LSU and MEMU, inside CPU.
// PARAMETERS
//   ADDR_W  32  address width, bits
//   DATA_W  32  data width, bits; mask width = DATA_W/8
// PORTS
//   clk           in   1         single clock, rising edge
//   rst_n         in   1         synchronous reset, active-low
//   if_valid      in   1         IFU request valid (read only)
//   if_addr       in   ADDR_W    IFU fetch address
//   if_ready      out  1         IFU request accepted (1-cycle pulse)
//   if_rsp_valid  out  1         IFU response valid
//   ls_valid      in   1         LSU request valid
//   ls_addr       in   ADDR_W    LSU address
//   ls_wen        in   1         1=store, 0=load
//   ls_wdata      in   DATA_W    store data
//   ls_wmask      in   DATA_W/8  store byte mask
//   ls_ready      out  1         LSU request accepted (1-cycle pulse)
//   ls_rsp_valid  out  1         LSU response (load data or store ack)
//   rsp_rdata     out  DATA_W    response data, shared by both masters
//   mem_req_valid out  1         request to MEMU
//   mem_req_ready in   1         MEMU accepts request
//   mem_addr/mem_wen/mem_wdata/mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8
//   mem_rsp_valid in   1         MEMU response valid
//   mem_rdata     in   DATA_W    MEMU read data
//   busy          out  1         state != IDLE
//   grant_id      out  1         0=IFU, 1=LSU; owner of current transaction
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): state=IDLE; all *_valid, *_ready, busy=0;
//     grant_id=0; latched req regs=0; rr pointer last=IFU.
//   - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//   - IDLE: if any master valid, pick winner; winner's *_ready=1 this cycle
//     (combinational); latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0);
//     set grant_id; go ISSUE. No valid: stay IDLE, readies 0.
//   - ISSUE: mem_req_valid=1 with latched fields (stable); on mem_req_ready=1
//     go WAIT; else hold.
//   - WAIT: on mem_rsp_valid=1, owner's *_rsp_valid=1 and rsp_rdata=mem_rdata
//     in that same cycle; go IDLE. The other master's rsp_valid stays 0.
//   - Latency: grant edge T0, earliest mem accept T1, earliest rsp T2;
//     next grant earliest in IDLE at T3.
//   - mem_rsp_valid in IDLE or ISSUE is ignored (no output, no state change).
//   - Masters hold valid+fields until *_ready; loser holds valid across cycles.
//   - Reset mid-transaction: abort to IDLE; a late mem_rsp is then ignored.
//   - rsp_rdata = 0 whenever no rsp_valid asserted.
//   - Arbitration without ARB_RR_EN: fixed priority, LSU beats IFU.
// CONFIGURATION
//   ARB_RR_EN defined: round-robin; on tie, grant master not granted last;
//     pointer updates on each grant; reset pointer = IFU (first tie -> LSU).
//   ARB_RR_EN undefined: fixed priority LSU > IFU; no pointer register.
// STRUCTURE
//   npc_pkg: state encoding (IDLE/ISSUE/WAIT), master IDs MID_IFU=0,
//     MID_LSU=1.
//   Sub-module arb_pick: combinational winner select (ifv, lsv, last) ->
//     (gnt_valid, gnt_id); instantiated once; holds the ARB_RR_EN branch.
// TESTING
//   1 IFU alone: if_addr=0x8000_0000, ready@T1, rsp@T3 rdata=0x0000_0013
//     -> if_ready pulse T0, if_rsp_valid 1 cycle, ls_rsp_valid=0 always.
//   2 LSU store: addr 0x8000_1000 wdata 0xDEAD_BEEF wmask 0xF -> mem fields
//     exact, held through 3-cycle mem_req_ready stall; ack on ls_rsp_valid.
//   3 Both valid in same cycle, fixed mode: LSU granted first, IFU next IDLE;
//     ARB_RR_EN: alternates LSU,IFU,LSU,... over 6 back-to-back ties.
//   4 Spurious mem_rsp_valid in IDLE/ISSUE -> no rsp_valid, state unchanged.
//   5 rst_n=0 during WAIT, then mem_rsp_valid -> IDLE, busy=0, no rsp_valid.
//   6 Random valid/stall/latency, 10k cycles: each master's responses are in
//     issue order and match a memory model; one transaction in flight max.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared types for the npc memory arbiter.
// FSM state encoding and master identifiers.
package npc_pkg;

  localparam int P_ADDR_W = 32;
  localparam int P_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU/LSU request-response and MEMU bus bundle.
// slave = arbiter view, master = view of the masters and memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rsp_valid;

  logic              ls_valid;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_wen;
  logic [DATA_W-1:0] ls_wdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              ls_ready;
  logic              ls_rsp_valid;

  logic [DATA_W-1:0] rsp_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_valid, if_addr,
    input  ls_valid, ls_addr, ls_wen,
    input  ls_wdata, ls_wmask,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rdata,
    output if_ready, if_rsp_valid,
    output ls_ready, ls_rsp_valid,
    output rsp_rdata,
    output mem_req_valid, mem_addr,
    output mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output if_valid, if_addr,
    output ls_valid, ls_addr, ls_wen,
    output ls_wdata, ls_wmask,
    output mem_req_ready,
    output mem_rsp_valid, mem_rdata,
    input  if_ready, if_rsp_valid,
    input  ls_ready, ls_rsp_valid,
    input  rsp_rdata,
    input  mem_req_valid, mem_addr,
    input  mem_wen, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational IFU/LSU winner select.
// ARB_RR_EN selects round-robin; default is fixed LSU > IFU.
module arb_pick
  import npc_pkg::*;
(
  input  logic ifv,
  input  logic lsv,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = ifv | lsv;

`ifdef ARB_RR_EN
  // a tie goes to whichever master was not served last
  always_comb begin
    gnt_id = MID_IFU;
    unique case ({ifv, lsv})
      2'b11:   gnt_id = ~last;
      2'b01:   gnt_id = MID_LSU;
      default: gnt_id = MID_IFU;
    endcase
  end
`else
  logic w_unused;
  assign w_unused = last;
  assign gnt_id   = lsv ? MID_LSU : MID_IFU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares MEMU between IFU and LSU, one transaction at a time.
// Define ARB_RR_EN for round-robin; default is fixed LSU > IFU priority.
module mem_arbiter
  import npc_pkg::*;
#(
  parameter int ADDR_W = P_ADDR_W,
  parameter int DATA_W = P_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic         busy,
  output logic         grant_id
);

  localparam int MASK_W = DATA_W / 8;

  state_t            r_state;
  state_t            w_next;
  logic              r_gid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;

  logic w_last;
  logic w_gnt_valid;
  logic w_gnt_id;
  logic w_take;

`ifdef ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last <= MID_IFU;
    else if (w_take)
      r_last <= w_gnt_id;
  end

  assign w_last = r_last;
`else
  assign w_last = MID_IFU;
`endif

  arb_pick u_pick (
    .ifv       (bus.if_valid),
    .lsv       (bus.ls_valid),
    .last      (w_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_take = (r_state == ST_IDLE)
                & w_gnt_valid;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // request fields stay frozen from grant until the next grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gid   <= MID_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_take) begin
      r_gid <= w_gnt_id;
      if (w_gnt_id == MID_LSU) begin
        r_addr  <= bus.ls_addr;
        r_wen   <= bus.ls_wen;
        r_wdata <= bus.ls_wdata;
        r_wmask <= bus.ls_wmask;
      end else begin
        r_addr  <= bus.if_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_gnt_valid) w_next = ST_ISSUE;
      ST_ISSUE:
        if (bus.mem_req_ready) w_next = ST_WAIT;
      ST_WAIT:
        if (bus.mem_rsp_valid) w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.if_ready      = 1'b0;
    bus.ls_ready      = 1'b0;
    bus.if_rsp_valid  = 1'b0;
    bus.ls_rsp_valid  = 1'b0;
    bus.rsp_rdata     = '0;
    bus.mem_req_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.if_ready = w_gnt_valid
                     & (w_gnt_id == MID_IFU);
        bus.ls_ready = w_gnt_valid
                     & (w_gnt_id == MID_LSU);
      end
      ST_ISSUE:
        bus.mem_req_valid = 1'b1;
      ST_WAIT:
        if (bus.mem_rsp_valid) begin
          bus.if_rsp_valid = (r_gid == MID_IFU);
          bus.ls_rsp_valid = (r_gid == MID_LSU);
          bus.rsp_rdata    = bus.mem_rdata;
        end
      default: ;
    endcase
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wen   = r_wen;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wmask = r_wmask;

  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_gid;

endmodule
